// File: rtl/lut_pkg.sv
// Shared constants and types for the LUT read-side blocks.
// The scan state enum is shared so the top and the FSM agree on encoding.
package lut_pkg;

   localparam int LUT_ADDR_W = 4;
   localparam int LUT_DEPTH  = 1 << LUT_ADDR_W;

   typedef logic [LUT_ADDR_W-1:0] lut_addr_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } scan_state_e;

endpackage

// File: rtl/lut_scan_fsm.sv
// Serial readback of the table snapshot: one bit per cycle, entry 0 first,
// followed by a single done cycle. No backpressure and no restart mid-scan.
module lut_scan_fsm
   import lut_pkg::*;
#(
   parameter int ADDR_W = LUT_ADDR_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    scan_start_i,
   input  logic [(1<<ADDR_W)-1:0]  snap_i,
   output logic                    start_acc_o,
   output logic                    scan_valid_o,
   output logic                    scan_bit_o,
   output logic                    scan_last_o,
   output logic                    scan_done_o,
   output logic                    scan_busy_o
);

   scan_state_e       state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // idx wraps naturally from DEPTH-1 back to 0 as the scan leaves SHIFT
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      scan_valid_o = 1'b0;
      scan_bit_o   = 1'b0;
      scan_last_o  = 1'b0;
      scan_done_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (scan_start_i) begin
               state_d = SHIFT;
               idx_d   = '0;
            end
         end
         SHIFT: begin
            scan_valid_o = 1'b1;
            scan_bit_o   = snap_i[idx_q];
            scan_last_o  = (idx_q == {ADDR_W{1'b1}});
            idx_d        = idx_q + ADDR_W'(1);
            if (idx_q == {ADDR_W{1'b1}}) begin
               state_d = DONE;
            end
         end
         DONE: begin
            scan_done_o = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign start_acc_o = (state_q == IDLE) && scan_start_i;
   assign scan_busy_o = (state_q != IDLE);

endmodule

// File: rtl/lut_table_reader.sv
// Read-side companion of the truth-table LUT writer: snapshot capture,
// single-bit lookups over valid/ready, and serial readback via lut_scan_fsm.
module lut_table_reader
   import lut_pkg::*;
#(
   parameter int ADDR_W = LUT_ADDR_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [(1<<ADDR_W)-1:0]  table_i,
   input  logic                    table_ld_i,
   input  logic                    rd_valid_i,
   input  logic [ADDR_W-1:0]       rd_addr_i,
   output logic                    rd_ready_o,
   output logic                    rsp_valid_o,
   output logic                    rsp_data_o,
   input  logic                    rsp_ready_i,
   input  logic                    scan_start_i,
   output logic                    scan_valid_o,
   output logic                    scan_bit_o,
   output logic                    scan_last_o,
   output logic                    scan_done_o,
   output logic                    scan_busy_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0] snap_q;
   logic [DEPTH-1:0] pend_q;
   logic             pend_flag;
   logic             start_acc;
   logic             rsp_valid_q;
   logic             rsp_data_q;
   logic             accept;

   lut_scan_fsm #(
      .ADDR_W (ADDR_W)
   ) u_scan (
      .clk          (clk),
      .rst          (rst),
      .scan_start_i (scan_start_i),
      .snap_i       (snap_q),
      .start_acc_o  (start_acc),
      .scan_valid_o (scan_valid_o),
      .scan_bit_o   (scan_bit_o),
      .scan_last_o  (scan_last_o),
      .scan_done_o  (scan_done_o),
      .scan_busy_o  (scan_busy_o)
   );

   // snap_q stays frozen while a scan runs; loads landing then are parked in
   // pend_q and promoted on the done cycle, where a fresh load takes priority
   always_ff @(posedge clk) begin
      if (rst) begin
         snap_q    <= '0;
         pend_q    <= '0;
         pend_flag <= 1'b0;
      end else if (scan_done_o) begin
         if (table_ld_i) begin
            snap_q <= table_i;
         end else if (pend_flag) begin
            snap_q <= pend_q;
         end
         pend_flag <= 1'b0;
      end else if (table_ld_i) begin
         if (scan_busy_o || start_acc) begin
            pend_q    <= table_i;
            pend_flag <= 1'b1;
         end else begin
            snap_q <= table_i;
         end
      end
   end

   assign rd_ready_o = !rsp_valid_q || rsp_ready_i;
   assign accept     = rd_valid_i && rd_ready_o;

   // One-deep response register; the response holds until the consumer takes it
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 1'b0;
      end else if (accept) begin
         rsp_valid_q <= 1'b1;
         rsp_data_q  <= snap_q[rd_addr_i];
      end else if (rsp_ready_i) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_lut_table_reader.sv
// Directed bench for lut_table_reader: a table-level reference model checked
// every cycle, plus literal expectations from the golden table 16'hFF4C.
module tb_lut_table_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] tableIn = '0;
   logic        tableLd = 1'b0;
   logic        rdValid = 1'b0;
   logic [3:0]  rdAddr = '0;
   logic        rdReady;
   logic        rspValid;
   logic        rspData;
   logic        rspReady = 1'b0;
   logic        scanStart = 1'b0;
   logic        scanValid;
   logic        scanBit;
   logic        scanLast;
   logic        scanDone;
   logic        scanBusy;

   int          vectors = 0;
   int          miscompares = 0;
   logic        checkEn = 1'b0;
   logic [15:0] golden = 16'hFF4C;

   // Reference model state: table contents and position within a scan
   // (-1 idle, 0..15 emitting that entry, 16 done cycle)
   logic [15:0] mSnap = '0;
   logic [15:0] mPend = '0;
   logic        mPendFlag = 1'b0;
   int          mPos = -1;
   logic        mRspValid = 1'b0;
   logic        mRspData = 1'b0;

   lut_table_reader dut (
      .clk          (clk),
      .rst          (rst),
      .table_i      (tableIn),
      .table_ld_i   (tableLd),
      .rd_valid_i   (rdValid),
      .rd_addr_i    (rdAddr),
      .rd_ready_o   (rdReady),
      .rsp_valid_o  (rspValid),
      .rsp_data_o   (rspData),
      .rsp_ready_i  (rspReady),
      .scan_start_i (scanStart),
      .scan_valid_o (scanValid),
      .scan_bit_o   (scanBit),
      .scan_last_o  (scanLast),
      .scan_done_o  (scanDone),
      .scan_busy_o  (scanBusy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Model: what the table and the handshake must look like after each edge
   always @(posedge clk) begin
      if (rst) begin
         mSnap     <= '0;
         mPend     <= '0;
         mPendFlag <= 1'b0;
         mPos      <= -1;
         mRspValid <= 1'b0;
         mRspData  <= 1'b0;
      end else begin
         if (rdValid && (!mRspValid || rspReady)) begin
            mRspValid <= 1'b1;
            mRspData  <= mSnap[rdAddr];
         end else if (rspReady) begin
            mRspValid <= 1'b0;
         end
         if (mPos < 0) mPos <= scanStart ? 0 : -1;
         else if (mPos == 16) mPos <= -1;
         else mPos <= mPos + 1;
         if (mPos == 16) begin
            if (tableLd) mSnap <= tableIn;
            else if (mPendFlag) mSnap <= mPend;
            mPendFlag <= 1'b0;
         end else if (tableLd) begin
            if (mPos < 0 && !scanStart) begin
               mSnap <= tableIn;
            end else begin
               mPend     <= tableIn;
               mPendFlag <= 1'b1;
            end
         end
      end
   end

   // Per-cycle comparison against the model, sampled mid-cycle
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("rd_ready", rdReady, !mRspValid || rspReady);
         checkOutput("rsp_valid", rspValid, mRspValid);
         if (mRspValid) checkOutput("rsp_data", rspData, mRspData);
         checkOutput("scan_valid", scanValid, (mPos >= 0) && (mPos < 16));
         if ((mPos >= 0) && (mPos < 16)) begin
            checkOutput("scan_bit", scanBit, mSnap[mPos[3:0]]);
            checkOutput("scan_last", scanLast, mPos == 15);
         end
         checkOutput("scan_done", scanDone, mPos == 16);
         checkOutput("scan_busy", scanBusy, mPos >= 0);
      end
   end

   initial begin
      applyStimulus();
      applyStimulus();
      checkEn = 1'b1;
      rst = 1'b0;
      checkOutput("reset_rd_ready", rdReady, 1'b1);
      checkOutput("reset_busy", scanBusy, 1'b0);

      // Reset mid-scan with a stalled response
      tableIn = 16'hFF4C; tableLd = 1'b1;
      applyStimulus();
      tableLd = 1'b0;
      scanStart = 1'b1; rdValid = 1'b1; rdAddr = 4'd3; rspReady = 1'b0;
      applyStimulus();
      scanStart = 1'b0; rdValid = 1'b0;
      repeat (3) applyStimulus();
      checkOutput("prereset_rsp_valid", rspValid, 1'b1);
      checkOutput("prereset_busy", scanBusy, 1'b1);
      rst = 1'b1;
      applyStimulus();
      applyStimulus();
      checkOutput("rst_rsp_valid", rspValid, 1'b0);
      checkOutput("rst_rsp_data", rspData, 1'b0);
      checkOutput("rst_rd_ready", rdReady, 1'b1);
      checkOutput("rst_scan_valid", scanValid, 1'b0);
      checkOutput("rst_scan_done", scanDone, 1'b0);
      checkOutput("rst_busy", scanBusy, 1'b0);
      rst = 1'b0;
      rdValid = 1'b1; rdAddr = 4'd5; rspReady = 1'b1;
      applyStimulus();
      rdValid = 1'b0;
      checkOutput("rst_lookup5_valid", rspValid, 1'b1);
      checkOutput("rst_lookup5_data", rspData, 1'b0);
      applyStimulus();

      // Full-throughput lookup sweep
      tableIn = 16'hFF4C; tableLd = 1'b1;
      applyStimulus();
      tableLd = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rdValid = 1'b1; rdAddr = 4'(i);
         applyStimulus();
         checkOutput("sweep_valid", rspValid, 1'b1);
         checkOutput("sweep_data", rspData, golden[i]);
      end
      rdValid = 1'b0;
      applyStimulus();

      // Backpressure: addr 6 held, addr 7 waits for rsp_ready
      rspReady = 1'b0; rdValid = 1'b1; rdAddr = 4'd6;
      applyStimulus();
      rdAddr = 4'd7;
      for (int i = 0; i < 3; i++) begin
         checkOutput("stall_data", rspData, 1'b1);
         checkOutput("stall_rd_ready", rdReady, 1'b0);
         applyStimulus();
      end
      rspReady = 1'b1;
      applyStimulus();
      rdValid = 1'b0;
      checkOutput("addr7_valid", rspValid, 1'b1);
      checkOutput("addr7_data", rspData, 1'b0);
      applyStimulus();
      checkOutput("drain_valid", rspValid, 1'b0);

      // Scan of the golden table, with an ignored restart mid-scan
      scanStart = 1'b1;
      applyStimulus();
      for (int k = 0; k < 16; k++) begin
         checkOutput("scan_valid_lit", scanValid, 1'b1);
         checkOutput("scan_bit_lit", scanBit, golden[k]);
         checkOutput("scan_last_lit", scanLast, k == 15);
         scanStart = (k == 7);
         applyStimulus();
      end
      scanStart = 1'b0;
      checkOutput("scan_done_lit", scanDone, 1'b1);
      checkOutput("scan_valid_end", scanValid, 1'b0);
      applyStimulus();
      checkOutput("scan_idle", scanBusy, 1'b0);

      // Load during scan: snapshot frozen, new table visible after done
      scanStart = 1'b1;
      applyStimulus();
      scanStart = 1'b0;
      for (int k = 0; k < 16; k++) begin
         checkOutput("frozen_bit", scanBit, golden[k]);
         tableLd = (k == 5); tableIn = 16'h0001;
         applyStimulus();
      end
      tableLd = 1'b0;
      applyStimulus();
      rdValid = 1'b1; rdAddr = 4'd0;
      applyStimulus();
      checkOutput("pend_addr0", rspData, 1'b1);
      rdAddr = 4'd8;
      applyStimulus();
      checkOutput("pend_addr8", rspData, 1'b0);
      rdValid = 1'b0;

      // Two loads during one scan: the later one wins
      scanStart = 1'b1;
      applyStimulus();
      scanStart = 1'b0;
      for (int k = 0; k < 16; k++) begin
         checkOutput("scan0001_bit", scanBit, k == 0);
         tableLd = (k == 3) || (k == 9);
         tableIn = (k == 3) ? 16'h00F0 : 16'h0F00;
         applyStimulus();
      end
      tableLd = 1'b0;
      applyStimulus();
      rdValid = 1'b1; rdAddr = 4'd4;
      applyStimulus();
      checkOutput("lastwins_addr4", rspData, 1'b0);
      rdAddr = 4'd8;
      applyStimulus();
      checkOutput("lastwins_addr8", rspData, 1'b1);
      rdValid = 1'b0;

      // Same-cycle read and load: request sees the old table
      tableIn = 16'hFF4C; tableLd = 1'b1;
      applyStimulus();
      tableIn = 16'h0000; rdValid = 1'b1; rdAddr = 4'd2;
      applyStimulus();
      tableLd = 1'b0;
      checkOutput("samecycle_old", rspData, 1'b1);
      applyStimulus();
      rdValid = 1'b0;
      checkOutput("samecycle_new", rspData, 1'b0);
      repeat (2) applyStimulus();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
